// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Each rising clock edge applies exactly one action, in priority order:
//   flush   : redirect PC to the word-aligned branch target, insert a bubble
//   stall   : hold PC and IF/ID unchanged
//   advance : latch the fetched word and PC+4 into IF/ID, step PC by 4
// Fetches at or beyond IM_WORDS*4 load a bubble (instr 0, valid 0), but the
// bubble still carries PC+4 and the PC still steps.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous active-low reset
//   stall_i          hold request from the hazard unit
//   flush_i          taken-branch redirect request
//   branch_target_i  redirect PC, used when flush_i=1
//   im_addr_o        byte address to instruction memory (current PC)
//   im_instr_i       instruction word for im_addr_o (combinational memory)
//   ifid_pc4_o       IF/ID PC+4
//   ifid_instr_o     IF/ID instruction
//   ifid_valid_o     IF/ID holds a real instruction (0 = bubble)
//   fetch_cnt_o      saturating count of valid instructions loaded
//   stall_cnt_o      saturating count of stall cycles
//   flush_cnt_o      saturating count of flush cycles
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IM_WORDS = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [31:0]      branch_target_i,
    output logic [31:0]      im_addr_o,
    input  logic [31:0]      im_instr_i,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned   ADDR_W    = 32;
    // Byte limit of the valid memory region; one extra bit plus margin so
    // large IM_WORDS values cannot overflow the comparison.
    localparam logic [33:0]   IM_LIMIT  = 34'(IM_WORDS) << 2;
    localparam logic [31:0]   ALIGN_MSK = ~32'h0000_0003;
    localparam logic [31:0]   RESET_AL  = RESET_PC & ALIGN_MSK;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_STALL   = 2'd1,
        ACT_FLUSH   = 2'd2
    } action_e;

    logic [ADDR_W-1:0] pc_q,         pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [31:0]       ifid_pc4_q,   ifid_pc4_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0]  fetch_cnt_q,  fetch_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q,  flush_cnt_d;

    action_e           action;
    logic [31:0]       pc_plus4;
    logic              pc_in_range;

    // Single action per edge: flush outranks stall, stall outranks advance.
    always_comb begin
        action = ACT_ADVANCE;
        if (flush_i) begin
            action = ACT_FLUSH;
        end else if (stall_i) begin
            action = ACT_STALL;
        end
    end

    assign pc_plus4    = pc_q + 32'd4;
    assign pc_in_range = (34'(pc_q) < IM_LIMIT);

    // Next-state for PC, IF/ID and counters.
    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        unique case (action)
            ACT_FLUSH: begin
                pc_d         = branch_target_i & ALIGN_MSK;
                ifid_instr_d = 32'h0;
                ifid_pc4_d   = 32'h0;
                ifid_valid_d = 1'b0;
                if (flush_cnt_q != CNT_MAX) begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end
            ACT_STALL: begin
                if (stall_cnt_q != CNT_MAX) begin
                    stall_cnt_d = stall_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                pc_d       = pc_plus4;
                ifid_pc4_d = pc_plus4;
                if (pc_in_range) begin
                    ifid_instr_d = im_instr_i;
                    ifid_valid_d = 1'b1;
                    if (fetch_cnt_q != CNT_MAX) begin
                        fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                    end
                end else begin
                    ifid_instr_d = 32'h0;
                    ifid_valid_d = 1'b0;
                end
            end
        endcase
    end

    // State registers; reset discards any pending stall/flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q         <= RESET_AL;
            ifid_instr_q <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign im_addr_o    = pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_valid_o = ifid_valid_q;
    assign fetch_cnt_o  = fetch_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed and random checks of if_stage against a
// transaction-level model of the fetch stage. Uses CNT_W=4 so counter
// saturation is reachable.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned IM_WORDS = 32;
    localparam int          CNT_SAT  = 15;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             stall_i;
    logic             flush_i;
    logic [31:0]      branch_target_i;
    logic [31:0]      im_addr_o;
    logic [31:0]      im_instr_i;
    logic [31:0]      ifid_pc4_o;
    logic [31:0]      ifid_instr_o;
    logic             ifid_valid_o;
    logic [CNT_W-1:0] fetch_cnt_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    // Backing store covers 64 words, twice the valid region, so out-of-range
    // fetches return non-zero data that the stage must discard.
    logic [31:0] imem [0:63];
    assign im_instr_i = (im_addr_o < 32'd256) ? imem[im_addr_o[7:2]] : 32'hDEAD_BEEF;

    always #5 clk_i = ~clk_i;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .IM_WORDS (IM_WORDS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .im_addr_o       (im_addr_o),
        .im_instr_i      (im_instr_i),
        .ifid_pc4_o      (ifid_pc4_o),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_valid_o    (ifid_valid_o),
        .fetch_cnt_o     (fetch_cnt_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    longint unsigned m_pc;
    logic [31:0]     m_instr;
    longint unsigned m_pc4;
    logic            m_valid;
    int              m_fc, m_sc, m_flc;

    task automatic model_reset();
        m_pc = 0; m_instr = 32'h0; m_pc4 = 0; m_valid = 1'b0;
        m_fc = 0; m_sc = 0; m_flc = 0;
    endtask

    // One clock of fetch behaviour, written from the action rules.
    task automatic model_edge(input logic s, input logic f, input logic [31:0] t);
        if (f) begin
            m_pc    = (longint'(t) / 4) * 4;
            m_instr = 32'h0;
            m_pc4   = 0;
            m_valid = 1'b0;
            if (m_flc < CNT_SAT) m_flc++;
        end else if (s) begin
            if (m_sc < CNT_SAT) m_sc++;
        end else begin
            m_pc4 = (m_pc + 4) % 64'h1_0000_0000;
            if (m_pc < IM_WORDS * 4) begin
                m_instr = imem[m_pc / 4];
                m_valid = 1'b1;
                if (m_fc < CNT_SAT) m_fc++;
            end else begin
                m_instr = 32'h0;
                m_valid = 1'b0;
            end
            m_pc = m_pc4;
        end
    endtask

    task automatic chk(input string tag, input string name,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, name, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, "im_addr",   im_addr_o,            32'(m_pc));
        chk(tag, "instr",     ifid_instr_o,         m_instr);
        chk(tag, "pc4",       ifid_pc4_o,           32'(m_pc4));
        chk(tag, "valid",     32'(ifid_valid_o),    32'(m_valid));
        chk(tag, "fetch_cnt", 32'(fetch_cnt_o),     32'(m_fc));
        chk(tag, "stall_cnt", 32'(stall_cnt_o),     32'(m_sc));
        chk(tag, "flush_cnt", 32'(flush_cnt_o),     32'(m_flc));
    endtask

    // Drive one action, clock it, check 1 time unit after the edge.
    task automatic step(input string tag, input logic s, input logic f,
                        input logic [31:0] t);
        stall_i = s; flush_i = f; branch_target_i = t;
        model_edge(s, f, t);
        @(posedge clk_i);
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges, check immediately, release away from edges.
    task automatic async_reset(input string tag);
        #2;
        rst_i = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk_i);
        #1;
        check_all(tag);
        #2;
        rst_i = 1'b1;
    endtask

    initial begin
        logic [31:0] tgt;
        int          r;
        for (int i = 0; i < 64; i++) imem[i] = $urandom | 32'h1;

        rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; branch_target_i = 32'h0;
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk_i);
        #1;
        check_all("reset_held");
        #2;
        rst_i = 1'b1;

        // Sequential fetch of IM[0..3]
        for (int i = 0; i < 4; i++) step("seq", 1'b0, 1'b0, 32'h0);
        chk("seq", "fetch_cnt4", 32'(fetch_cnt_o), 32'd4);
        chk("seq", "pc4_16",     ifid_pc4_o,       32'd16);

        // Stall holding B, then load C
        async_reset("rst2");
        step("adv", 1'b0, 1'b0, 32'h0);
        step("adv", 1'b0, 1'b0, 32'h0);
        step("stall", 1'b1, 1'b0, 32'h0);
        step("stall", 1'b1, 1'b0, 32'h0);
        chk("stall", "hold_addr", im_addr_o,  32'd8);
        chk("stall", "hold_b",    ifid_instr_o, imem[1]);
        step("post_stall", 1'b0, 1'b0, 32'h0);
        chk("post_stall", "load_c", ifid_instr_o, imem[2]);

        // Flush wins over stall; unaligned target gets aligned
        step("flush_stall", 1'b1, 1'b1, 32'h0000_0013);
        chk("flush_stall", "pc_aligned", im_addr_o, 32'h0000_0010);
        step("after_flush", 1'b0, 1'b0, 32'h0);

        // Boundary of the valid memory region
        step("flush124", 1'b0, 1'b1, 32'd124);
        step("last_word", 1'b0, 1'b0, 32'h0);
        step("out_range", 1'b0, 1'b0, 32'h0);
        chk("out_range", "pc4_132", ifid_pc4_o, 32'd132);
        step("out_range2", 1'b0, 1'b0, 32'h0);

        // PC wrap past the top of the address space
        step("flush_top", 1'b0, 1'b1, 32'hFFFF_FFFE);
        step("wrap", 1'b0, 1'b0, 32'h0);
        chk("wrap", "pc_zero", im_addr_o, 32'h0);

        // Counter saturation
        for (int i = 0; i < 20; i++) step("sat", 1'b1, 1'b0, 32'h0);
        chk("sat", "stall_15", 32'(stall_cnt_o), 32'd15);

        // Async reset while stalled at PC=8
        async_reset("rst3");
        step("adv", 1'b0, 1'b0, 32'h0);
        step("adv", 1'b0, 1'b0, 32'h0);
        stall_i = 1'b1; flush_i = 1'b1; branch_target_i = 32'h40;
        async_reset("rst_mid");
        step("after_rst", 1'b0, 1'b0, 32'h0);
        chk("after_rst", "im0", ifid_instr_o, imem[0]);

        // Random actions
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r == 99) begin
                async_reset("rnd_rst");
            end else begin
                if ($urandom_range(0, 19) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                else tgt = 32'($urandom_range(0, 160));
                step("rnd", ($urandom_range(0, 3) == 0), (r < 10), tgt);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
